// File: rtl/axi_stream_upsizing.sv
// axi_stream_upsizing: packs a narrow AXI-stream (1<<IEW bytes/beat) into a
// wide AXI-stream (1<<OEW bytes/beat), filling lanes little-endian.
// A word goes out early on i_tlast. Partial words carry tkeep marking the
// bytes that were written. Bytes whose input keep bit is clear are stored
// as zero, so unwritten and unkept lanes always read back as data=0, keep=0.
module axi_stream_upsizing #(
    parameter int IEW = 0,
    parameter int OEW = 2
) (
    input  logic                  rstn,
    input  logic                  clk,
    output logic                  i_tready,
    input  logic                  i_tvalid,
    input  logic [(8<<IEW)-1:0]   i_tdata,
    input  logic [(1<<IEW)-1:0]   i_tkeep,
    input  logic                  i_tlast,
    input  logic                  o_tready,
    output logic                  o_tvalid,
    output logic [(8<<OEW)-1:0]   o_tdata,
    output logic [(1<<OEW)-1:0]   o_tkeep,
    output logic                  o_tlast
);

    localparam int IDXW = OEW - IEW;
    localparam int R    = 1 << IDXW;
    localparam int IB   = 1 << IEW;
    localparam int OB   = 1 << OEW;

    logic [8*OB-1:0] acc_data_q, acc_data_d;
    logic [OB-1:0]   acc_keep_q, acc_keep_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            o_tvalid_q, o_tvalid_d;
    logic [8*OB-1:0] o_tdata_q, o_tdata_d;
    logic [OB-1:0]   o_tkeep_q, o_tkeep_d;
    logic            o_tlast_q, o_tlast_d;

    logic [8*OB-1:0] merged_data;
    logic [OB-1:0]   merged_keep;
    logic            accept;
    logic            null_beat;
    logic            completing;
    logic            flush;

    // Ready depends only on the output register state and o_tready.
    assign i_tready   = ~o_tvalid_q | o_tready;
    assign accept     = i_tvalid & i_tready;
    assign null_beat  = (i_tkeep == '0);
    assign completing = accept & ~null_beat & ((idx_q == IDXW'(R - 1)) | i_tlast);
    assign flush      = accept & null_beat & i_tlast & (acc_keep_q != '0);

    // Accumulator with the incoming beat dropped into lane group idx.
    always_comb begin
        merged_data = acc_data_q;
        merged_keep = acc_keep_q;
        for (int g = 0; g < R; g++) begin
            if (idx_q == IDXW'(g)) begin
                for (int b = 0; b < IB; b++) begin
                    merged_data[(g*IB+b)*8 +: 8] = i_tkeep[b] ? i_tdata[b*8 +: 8] : 8'h00;
                    merged_keep[g*IB+b]          = i_tkeep[b];
                end
            end
        end
    end

    // Next-state for accumulator and output register.
    always_comb begin
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        idx_d      = idx_q;
        o_tvalid_d = o_tvalid_q;
        o_tdata_d  = o_tdata_q;
        o_tkeep_d  = o_tkeep_q;
        o_tlast_d  = o_tlast_q;

        if (o_tready) begin
            o_tvalid_d = 1'b0;
        end

        if (completing) begin
            o_tvalid_d = 1'b1;
            o_tdata_d  = merged_data;
            o_tkeep_d  = merged_keep;
            o_tlast_d  = i_tlast;
            acc_data_d = '0;
            acc_keep_d = '0;
            idx_d      = '0;
        end else if (flush) begin
            o_tvalid_d = 1'b1;
            o_tdata_d  = acc_data_q;
            o_tkeep_d  = acc_keep_q;
            o_tlast_d  = 1'b1;
            acc_data_d = '0;
            acc_keep_d = '0;
            idx_d      = '0;
        end else if (accept && !null_beat) begin
            acc_data_d = merged_data;
            acc_keep_d = merged_keep;
            idx_d      = idx_q + IDXW'(1);
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_data_q <= '0;
            acc_keep_q <= '0;
            idx_q      <= '0;
            o_tvalid_q <= 1'b0;
            o_tdata_q  <= '0;
            o_tkeep_q  <= '0;
            o_tlast_q  <= 1'b0;
        end else begin
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            idx_q      <= idx_d;
            o_tvalid_q <= o_tvalid_d;
            o_tdata_q  <= o_tdata_d;
            o_tkeep_q  <= o_tkeep_d;
            o_tlast_q  <= o_tlast_d;
        end
    end

    assign o_tvalid = o_tvalid_q;
    assign o_tdata  = o_tdata_q;
    assign o_tkeep  = o_tkeep_q;
    assign o_tlast  = o_tlast_q;

endmodule

// File: tb/tb_axi_stream_upsizing.sv
// Directed bench for axi_stream_upsizing: a 1B->4B instance driven from a
// per-cycle vector table, plus hand sequences for async reset mid-packet
// and a 2B->8B instance with sparse keep.
module tb_axi_stream_upsizing;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // 1B -> 4B instance
    logic        a_i_tready, a_i_tvalid, a_i_tlast, a_o_tready, a_o_tvalid, a_o_tlast;
    logic [7:0]  a_i_tdata;
    logic [0:0]  a_i_tkeep;
    logic [31:0] a_o_tdata;
    logic [3:0]  a_o_tkeep;

    // 2B -> 8B instance
    logic        b_i_tready, b_i_tvalid, b_i_tlast, b_o_tready, b_o_tvalid, b_o_tlast;
    logic [15:0] b_i_tdata;
    logic [1:0]  b_i_tkeep;
    logic [63:0] b_o_tdata;
    logic [7:0]  b_o_tkeep;

    axi_stream_upsizing #(.IEW(0), .OEW(2)) dut_a (
        .rstn(rstn), .clk(clk),
        .i_tready(a_i_tready), .i_tvalid(a_i_tvalid), .i_tdata(a_i_tdata),
        .i_tkeep(a_i_tkeep), .i_tlast(a_i_tlast),
        .o_tready(a_o_tready), .o_tvalid(a_o_tvalid), .o_tdata(a_o_tdata),
        .o_tkeep(a_o_tkeep), .o_tlast(a_o_tlast)
    );

    axi_stream_upsizing #(.IEW(1), .OEW(3)) dut_b (
        .rstn(rstn), .clk(clk),
        .i_tready(b_i_tready), .i_tvalid(b_i_tvalid), .i_tdata(b_i_tdata),
        .i_tkeep(b_i_tkeep), .i_tlast(b_i_tlast),
        .o_tready(b_o_tready), .o_tvalid(b_o_tvalid), .o_tdata(b_o_tdata),
        .o_tkeep(b_o_tkeep), .o_tlast(b_o_tlast)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One row per clock: inputs applied this cycle, outputs expected to be
    // visible during this cycle (i.e. before the capturing edge).
    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        k;
        logic        l;
        logic        rdy;
        logic        e_rdy;
        logic        e_val;
        logic [31:0] e_data;
        logic [3:0]  e_keep;
        logic        e_last;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] d, input logic k, input logic l,
                       input logic rdy, input logic e_rdy, input logic e_val,
                       input logic [31:0] e_data, input logic [3:0] e_keep, input logic e_last);
        vec_t r;
        r.v = v; r.d = d; r.k = k; r.l = l; r.rdy = rdy;
        r.e_rdy = e_rdy; r.e_val = e_val; r.e_data = e_data; r.e_keep = e_keep; r.e_last = e_last;
        vecs.push_back(r);
    endtask

    task automatic drive_a(input logic v, input logic [7:0] d, input logic k, input logic l,
                           input logic rdy);
        a_i_tvalid = v; a_i_tdata = d; a_i_tkeep = k; a_i_tlast = l; a_o_tready = rdy;
    endtask

    initial begin
        rstn = 1'b0;
        drive_a(0, 8'h00, 0, 0, 1);
        b_i_tvalid = 0; b_i_tdata = '0; b_i_tkeep = '0; b_i_tlast = 0; b_o_tready = 1;

        //   v  d      k  l  rdy e_rdy e_val e_data        e_keep  e_last
        // full word
        add(1, 8'h11, 1, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'h22, 1, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'h33, 1, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'h44, 1, 1, 1,  1,    0,    32'h0,        4'h0,   0);
        add(0, 8'h00, 0, 0, 1,  1,    1,    32'h44332211, 4'hF,   1);
        // partial flush, next packet starts in lane 0
        add(1, 8'hAA, 1, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'hBB, 1, 1, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'hCC, 1, 0, 1,  1,    1,    32'h0000BBAA, 4'h3,   1);
        add(1, 8'hDD, 1, 1, 1,  1,    0,    32'h0,        4'h0,   0);
        add(0, 8'h00, 0, 0, 1,  1,    1,    32'h0000DDCC, 4'h3,   1);
        // null beats: mid-word drop, flush on null last, null last when empty
        add(1, 8'h55, 1, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'hFF, 0, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'h66, 1, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'hEE, 0, 1, 1,  1,    0,    32'h0,        4'h0,   0);
        add(0, 8'h00, 0, 0, 1,  1,    1,    32'h00006655, 4'h3,   1);
        add(1, 8'h77, 0, 1, 1,  1,    0,    32'h0,        4'h0,   0);
        add(0, 8'h00, 0, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        // backpressure: 01..08 with a 5-cycle stall while word 1 is pending
        add(1, 8'h01, 1, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'h02, 1, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'h03, 1, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'h04, 1, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        for (int i = 0; i < 5; i++)
            add(1, 8'h05, 1, 0, 0,  0,    1,    32'h04030201, 4'hF,   0);
        add(1, 8'h05, 1, 0, 1,  1,    1,    32'h04030201, 4'hF,   0);
        add(1, 8'h06, 1, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'h07, 1, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'h08, 1, 1, 1,  1,    0,    32'h0,        4'h0,   0);
        add(0, 8'h00, 0, 0, 1,  1,    1,    32'h08070605, 4'hF,   1);
        add(0, 8'h00, 0, 0, 1,  1,    0,    32'h0,        4'h0,   0);
        // transfer and new completing beat in the same cycle: no bubble
        add(1, 8'h11, 1, 1, 1,  1,    0,    32'h0,        4'h0,   0);
        add(1, 8'h22, 1, 1, 1,  1,    1,    32'h00000011, 4'h1,   1);
        add(0, 8'h00, 0, 0, 1,  1,    1,    32'h00000022, 4'h1,   1);
        add(0, 8'h00, 0, 0, 1,  1,    0,    32'h0,        4'h0,   0);

        // reset state
        repeat (2) @(negedge clk);
        check("reset a_o_tvalid", 64'(a_o_tvalid), 64'h0);
        check("reset a_o_tdata",  64'(a_o_tdata),  64'h0);
        check("reset a_o_tkeep",  64'(a_o_tkeep),  64'h0);
        check("reset a_o_tlast",  64'(a_o_tlast),  64'h0);
        check("reset b_o_tvalid", 64'(b_o_tvalid), 64'h0);
        check("reset a_i_tready", 64'(a_i_tready), 64'h1);
        rstn = 1'b1;

        foreach (vecs[n]) begin
            @(negedge clk);
            drive_a(vecs[n].v, vecs[n].d, vecs[n].k, vecs[n].l, vecs[n].rdy);
            #1;
            check($sformatf("row%0d i_tready", n), 64'(a_i_tready), 64'(vecs[n].e_rdy));
            check($sformatf("row%0d o_tvalid", n), 64'(a_o_tvalid), 64'(vecs[n].e_val));
            if (vecs[n].e_val) begin
                check($sformatf("row%0d o_tdata", n), 64'(a_o_tdata), 64'(vecs[n].e_data));
                check($sformatf("row%0d o_tkeep", n), 64'(a_o_tkeep), 64'(vecs[n].e_keep));
                check($sformatf("row%0d o_tlast", n), 64'(a_o_tlast), 64'(vecs[n].e_last));
            end
        end

        // async reset after 3 accepted bytes
        @(negedge clk); drive_a(1, 8'hC1, 1, 0, 1);
        @(negedge clk); drive_a(1, 8'hC2, 1, 0, 1);
        @(negedge clk); drive_a(1, 8'hC3, 1, 0, 1);
        @(negedge clk); drive_a(0, 8'h00, 0, 0, 1);
        #2 rstn = 1'b0;
        #1;
        check("midreset o_tvalid", 64'(a_o_tvalid), 64'h0);
        check("midreset o_tdata",  64'(a_o_tdata),  64'h0);
        check("midreset o_tkeep",  64'(a_o_tkeep),  64'h0);
        check("midreset o_tlast",  64'(a_o_tlast),  64'h0);
        @(negedge clk); rstn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); drive_a(1, 8'(i), 1, 0, 1);
        end
        @(negedge clk); drive_a(0, 8'h00, 0, 0, 1);
        #1;
        check("postreset o_tvalid", 64'(a_o_tvalid), 64'h1);
        check("postreset o_tdata",  64'(a_o_tdata),  64'h04030201);
        check("postreset o_tkeep",  64'(a_o_tkeep),  64'hF);
        check("postreset o_tlast",  64'(a_o_tlast),  64'h0);

        // 2B -> 8B with a sparse-keep beat in the middle
        @(negedge clk);
        b_i_tvalid = 1; b_i_tdata = 16'h2211; b_i_tkeep = 2'b11; b_i_tlast = 0;
        #1 check("b i_tready", 64'(b_i_tready), 64'h1);
        @(negedge clk);
        b_i_tdata = 16'h4433; b_i_tkeep = 2'b01;
        @(negedge clk);
        b_i_tdata = 16'h6655; b_i_tkeep = 2'b11; b_i_tlast = 1;
        #1 check("b o_tvalid before", 64'(b_o_tvalid), 64'h0);
        @(negedge clk);
        b_i_tvalid = 0; b_i_tkeep = 2'b00; b_i_tlast = 0;
        #1;
        check("b o_tvalid", 64'(b_o_tvalid), 64'h1);
        check("b o_tdata",  b_o_tdata,       64'h0000665500332211);
        check("b o_tkeep",  64'(b_o_tkeep),  64'h37);
        check("b o_tlast",  64'(b_o_tlast),  64'h1);
        @(negedge clk);
        #1 check("b o_tvalid after", 64'(b_o_tvalid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_stream_upsizing.md
Name: axi_stream_upsizing

Overview:
- Packs a narrow AXI-stream (1<<IEW bytes/beat) into a wide AXI-stream (1<<OEW bytes/beat), filling lanes little-endian (first accepted beat lands in the lowest lanes).
- Used in the receive direction between the FTDI byte stream and user logic; it is the width-converting counterpart of the downsizing stage on the transmit side.
- A word is flushed early on i_tlast; partial words carry tkeep marking the valid bytes.

Parameters:
- IEW, 0, input width exponent: 0=1B, 1=2B, 2=4B, ...
- OEW, 2, output width exponent; OEW must be > IEW.
- Ratio R = 1<<(OEW-IEW) input beats per output word.

Ports:
- rstn  input  1  asynchronous reset, active-low
- clk  input  1  clock
- i_tready  output  1  slave ready
- i_tvalid  input  1  slave valid
- i_tdata  input  8<<IEW  slave data
- i_tkeep  input  1<<IEW  slave byte-keep
- i_tlast  input  1  slave packet end
- o_tready  input  1  master ready
- o_tvalid  output  1  master valid
- o_tdata  output  8<<OEW  master data
- o_tkeep  output  1<<OEW  master byte-keep
- o_tlast  output  1  master packet end

Behaviour:
- State:
  - Accumulator: acc_data, acc_keep, slot index idx (OEW-IEW bits).
  - Output register: o_tdata, o_tkeep, o_tlast, o_tvalid.
- Reset (async, rstn=0): acc_data=0, acc_keep=0, idx=0, o_tvalid=0, o_tdata=0, o_tkeep=0, o_tlast=0.
- Handshakes:
  - i_tready = ~o_tvalid | o_tready, combinational from o_tready only; never depends on i_tvalid.
  - Input accepted when i_tvalid & i_tready.
  - Output transfer when o_tvalid & o_tready.
- Lane placement: an accepted beat writes i_tdata/i_tkeep into lane group idx, i.e. bytes [idx*(1<<IEW) +: 1<<IEW]. Lanes not yet written in the current word hold keep=0 and data=0.
- Null beat (i_tkeep==0):
  - With i_tlast=0: accepted and discarded; idx unchanged.
  - With i_tlast=1 and acc_keep!=0: flush the accumulator as-is with tlast=1.
  - With i_tlast=1 and acc_keep==0: discarded, no output.
- Completing beat (non-null and idx==R-1, or non-null with i_tlast=1):
  - Next cycle: o_tvalid=1, o_tdata/o_tkeep = accumulator merged with this beat, o_tlast=i_tlast.
  - Accumulator cleared, idx=0.
- Non-completing non-null beat: merged into the accumulator, idx+1. Output register is unaffected unless an output transfer occurs in the same cycle, in which case o_tvalid falls to 0.
- Output register:
  - Loads only on a completing beat or a flush.
  - Otherwise, when o_tready=1 it clears o_tvalid (o_tdata/o_tkeep/o_tlast may hold stale values but o_tvalid=0).
  - Holds stable while o_tvalid & ~o_tready.
- Latency: 1 cycle from acceptance of the completing beat to o_tvalid.
- Throughput: one input beat per cycle while o_tready=1; back-to-back output words every R cycles at full rate.
- Simultaneous events: an output transfer and a completing-beat acceptance in the same cycle → the register reloads with the new word and o_tvalid stays 1 (no bubble).
- Backpressure: while o_tvalid & ~o_tready, i_tready=0, so no beats are accepted, including non-completing ones.
- Sparse keep: i_tkeep patterns are copied verbatim, with no compaction. The downstream stage must tolerate holes.
- Reset mid-packet: all accumulated bytes and any pending output are discarded; the first beat after reset lands in lane group 0.

Test Plan (IEW=0, OEW=2, R=4 unless noted):
- Full word: bytes 11,22,33,44 back-to-back, keep=1, last on 44, o_tready=1 → one output: tdata=0x44332211, tkeep=4'b1111, tlast=1, o_tvalid exactly 1 cycle after the 44 beat.
- Partial flush: 0xAA, 0xBB(last) → tdata=0x0000BBAA, tkeep=4'b0011, tlast=1; the next packet byte 0xCC lands in lane 0.
- Backpressure: 8 bytes 01..08 streamed while o_tready is held 0 from cycle 3 for 5 cycles → i_tready=0 during the stall, o_tdata held at 0x04030201; after release, words 0x04030201 then 0x08070605 are emitted with no data loss or duplication.
- Null beats:
  - keep=0, last=0 mid-word → dropped, idx unchanged.
  - keep=0, last=1 after 2 bytes (0x55,0x66) → tdata=0x00006655, tkeep=4'b0011, tlast=1.
  - keep=0, last=1 with an empty accumulator → no output.
- Async reset after 3 accepted bytes → all outputs 0 immediately; next bytes 0x01..0x04 produce 0x04030201.
- IEW=1, OEW=3: 2-byte beats 0x2211, 0x4433 (keep 2'b01), 0x6655(last) → tdata=0x0000665500332211, tkeep=8'b00110111, tlast=1.
